wb_arbiter: RTL and testbench



---
 rtl/wb_arbiter.sv | 137 +++++++++++++
 tb/tb_wb_arbiter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges execute results and FIFO-buffered load results onto the single RF write port, plus a pending-load scoreboard.
// Optional performance counters are built only when WB_PERF_EN is defined.
module wb_arbiter #(
   parameter int XLEN  = 64,
   parameter int AW    = 5,
   parameter int DEPTH = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 exe_valid,
   input  logic                 exe_wen,
   input  logic [AW-1:0]        exe_rd,
   input  logic [XLEN-1:0]      exe_wdata,
   output logic                 exe_ready,
   input  logic                 lsu_valid,
   input  logic [AW-1:0]        lsu_rd,
   input  logic [XLEN-1:0]      lsu_wdata,
   output logic                 lsu_ready,
   input  logic                 ld_issue_valid,
   input  logic [AW-1:0]        ld_issue_rd,
   output logic [(1<<AW)-1:0]   pend_mask,
   output logic                 rf_we,
   output logic [AW-1:0]        rf_waddr,
   output logic [XLEN-1:0]      rf_wdata,
   output logic [31:0]          perf_wr_cnt,
   output logic [31:0]          perf_stall_cnt
);

   localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW   = $clog2(DEPTH) + 1;
   localparam int NREG = 1 << AW;

   logic [AW-1:0]   fifo_rd   [DEPTH];
   logic [XLEN-1:0] fifo_data [DEPTH];
   logic [PW-1:0]   wr_ptr, rd_ptr;
   logic [CW-1:0]   count;
   logic            full, empty, push, pop, exe_win;
   logic [AW-1:0]   head_rd;
   logic [XLEN-1:0] head_data;
   logic            wr_en_d;
   logic [AW-1:0]   wr_addr_d;
   logic [XLEN-1:0] wr_data_d;
   logic [NREG-1:0] set_vec, clr_vec, pend_next;

   assign full      = (count == CW'(DEPTH));
   assign empty     = (count == '0);
   assign lsu_ready = !full;
   assign exe_ready = !full;
   assign push      = lsu_valid && !full;
   assign exe_win   = exe_valid && !full;
   // A full FIFO takes priority over execute so loads can never starve.
   assign pop       = !empty && (full || !exe_valid);
   assign head_rd   = fifo_rd[rd_ptr];
   assign head_data = fifo_data[rd_ptr];

   always_comb begin
      wr_en_d   = 1'b0;
      wr_addr_d = head_rd;
      wr_data_d = head_data;
      if (pop) begin
         wr_en_d = (head_rd != '0);
      end else if (exe_win) begin
         wr_en_d   = exe_wen && (exe_rd != '0);
         wr_addr_d = exe_rd;
         wr_data_d = exe_wdata;
      end
   end

   always_comb begin
      set_vec = '0;
      clr_vec = '0;
      if (ld_issue_valid)
         set_vec = {{(NREG-1){1'b0}}, 1'b1} << ld_issue_rd;
      if (pop)
         clr_vec = {{(NREG-1){1'b0}}, 1'b1} << head_rd;
      pend_next    = (pend_mask & ~clr_vec) | set_vec;
      pend_next[0] = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            fifo_rd[i]   <= '0;
            fifo_data[i] <= '0;
         end
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            fifo_rd[wr_ptr]   <= lsu_rd;
            fifo_data[wr_ptr] <= lsu_wdata;
            wr_ptr            <= wr_ptr + 1'b1;
         end
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)
            count <= count + 1'b1;
         else if (pop && !push)
            count <= count - 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rf_we     <= 1'b0;
         rf_waddr  <= '0;
         rf_wdata  <= '0;
         pend_mask <= '0;
      end else begin
         rf_we     <= wr_en_d;
         pend_mask <= pend_next;
         if (pop || exe_win) begin
            rf_waddr <= wr_addr_d;
            rf_wdata <= wr_data_d;
         end
      end
   end

`ifdef WB_PERF_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_wr_cnt    <= '0;
         perf_stall_cnt <= '0;
      end else begin
         if (rf_we)
            perf_wr_cnt <= perf_wr_cnt + 32'd1;
         if (exe_valid && !exe_ready)
            perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
   end
`else
   assign perf_wr_cnt    = '0;
   assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: execute path, load path, FIFO-full priority, rd=0, scoreboard set/clear race, mid-run reset.
module tb_wb_arbiter;
   localparam int XLEN = 64;
   localparam int AW   = 5;

`ifdef WB_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            rst;
   logic            exe_valid, exe_wen;
   logic [AW-1:0]   exe_rd;
   logic [XLEN-1:0] exe_wdata;
   logic            exe_ready;
   logic            lsu_valid;
   logic [AW-1:0]   lsu_rd;
   logic [XLEN-1:0] lsu_wdata;
   logic            lsu_ready;
   logic            ld_issue_valid;
   logic [AW-1:0]   ld_issue_rd;
   logic [31:0]     pend_mask;
   logic            rf_we;
   logic [AW-1:0]   rf_waddr;
   logic [XLEN-1:0] rf_wdata;
   logic [31:0]     perf_wr_cnt, perf_stall_cnt;

   int pass_cnt  = 0;
   int total_cnt = 0;

   wb_arbiter #(.XLEN(XLEN), .AW(AW), .DEPTH(2)) dut (
      .clk(clk), .rst(rst),
      .exe_valid(exe_valid), .exe_wen(exe_wen), .exe_rd(exe_rd), .exe_wdata(exe_wdata),
      .exe_ready(exe_ready),
      .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_wdata(lsu_wdata), .lsu_ready(lsu_ready),
      .ld_issue_valid(ld_issue_valid), .ld_issue_rd(ld_issue_rd),
      .pend_mask(pend_mask),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .perf_wr_cnt(perf_wr_cnt), .perf_stall_cnt(perf_stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   initial begin
      rst = 1'b1;
      exe_valid = 0; exe_wen = 0; exe_rd = '0; exe_wdata = '0;
      lsu_valid = 0; lsu_rd = '0; lsu_wdata = '0;
      ld_issue_valid = 0; ld_issue_rd = '0;
      tick();
      tick();
      chk("rst_exe_ready", exe_ready, 1);
      chk("rst_lsu_ready", lsu_ready, 1);
      chk("rst_rf_we", rf_we, 0);
      chk("rst_rf_waddr", rf_waddr, 0);
      chk("rst_rf_wdata", rf_wdata, 0);
      chk("rst_pend", pend_mask, 0);
      chk("rst_wr_cnt", perf_wr_cnt, 0);
      chk("rst_stall_cnt", perf_stall_cnt, 0);
      rst = 1'b0;
      tick();

      // execute only
      exe_valid = 1; exe_wen = 1; exe_rd = 5; exe_wdata = 64'h1234;
      #1 chk("exe_ready_t", exe_ready, 1);
      tick();
      chk("exe_we", rf_we, 1);
      chk("exe_waddr", rf_waddr, 5);
      chk("exe_wdata", rf_wdata, 64'h1234);
      chk("exe_ready_t1", exe_ready, 1);
      exe_valid = 0;
      tick();
      chk("exe_we_once", rf_we, 0);

      // load path and scoreboard
      ld_issue_valid = 1; ld_issue_rd = 7;
      tick();
      chk("ld_pend_set", pend_mask, 32'h80);
      ld_issue_valid = 0;
      lsu_valid = 1; lsu_rd = 7; lsu_wdata = 64'hDEAD;
      tick();
      chk("ld_push_no_we", rf_we, 0);
      chk("ld_pend_hold", pend_mask, 32'h80);
      lsu_valid = 0;
      tick();
      chk("ld_we", rf_we, 1);
      chk("ld_waddr", rf_waddr, 7);
      chk("ld_wdata", rf_wdata, 64'hDEAD);
      chk("ld_pend_clr", pend_mask, 0);
      tick();
      chk("ld_we_once", rf_we, 0);

      // FIFO full with execute held valid
      exe_valid = 1; exe_wen = 1; exe_rd = 10; exe_wdata = 64'hA0;
      lsu_valid = 1; lsu_rd = 11; lsu_wdata = 64'hB0;
      tick();
      chk("full_exe1_addr", rf_waddr, 10);
      lsu_rd = 12; lsu_wdata = 64'hC0;
      tick();
      lsu_valid = 0;
      #1;
      chk("full_lsu_ready", lsu_ready, 0);
      chk("full_exe_ready", exe_ready, 0);
      tick();
      chk("full_drain_we", rf_we, 1);
      chk("full_drain_addr", rf_waddr, 11);
      chk("full_drain_data", rf_wdata, 64'hB0);
      chk("full_exe_ready_back", exe_ready, 1);
      chk("full_stall_cnt", perf_stall_cnt, PERF ? 1 : 0);
      tick();
      chk("full_exe2_addr", rf_waddr, 10);
      exe_valid = 0;
      tick();
      chk("full_tail_addr", rf_waddr, 12);
      chk("full_tail_data", rf_wdata, 64'hC0);
      tick();
      chk("full_idle_we", rf_we, 0);
      chk("wr_cnt_total", perf_wr_cnt, PERF ? 7 : 0);

      // rd = 0 and exe_wen = 0
      exe_valid = 1; exe_wen = 1; exe_rd = 0; exe_wdata = 64'hFF;
      tick();
      chk("rd0_exe_we", rf_we, 0);
      exe_wen = 0; exe_rd = 6;
      tick();
      chk("nowen_exe_we", rf_we, 0);
      exe_valid = 0;
      lsu_valid = 1; lsu_rd = 0; lsu_wdata = 64'hEE;
      ld_issue_valid = 1; ld_issue_rd = 0;
      tick();
      chk("rd0_pend", pend_mask, 0);
      lsu_valid = 0; ld_issue_valid = 0;
      tick();
      chk("rd0_ld_we", rf_we, 0);
      chk("rd0_fifo_empty", lsu_ready, 1);

      // same-cycle set and clear
      ld_issue_valid = 1; ld_issue_rd = 3;
      tick();
      ld_issue_valid = 0;
      lsu_valid = 1; lsu_rd = 3; lsu_wdata = 64'h33;
      tick();
      lsu_valid = 0;
      ld_issue_valid = 1; ld_issue_rd = 3;
      tick();
      chk("race_we", rf_we, 1);
      chk("race_waddr", rf_waddr, 3);
      chk("race_pend", pend_mask, 32'h8);
      ld_issue_valid = 0;
      lsu_valid = 1; lsu_rd = 3; lsu_wdata = 64'h34;
      tick();
      lsu_valid = 0;
      tick();
      chk("race_pend_clr", pend_mask, 0);

      // reset mid-operation
      ld_issue_valid = 1; ld_issue_rd = 9;
      exe_valid = 1; exe_wen = 1; exe_rd = 4; exe_wdata = 64'h44;
      tick();
      ld_issue_valid = 0;
      lsu_valid = 1; lsu_rd = 9; lsu_wdata = 64'h99;
      tick();
      chk("mid_pend9", pend_mask, 32'h200);
      chk("mid_we", rf_we, 1);
      exe_valid = 0; lsu_valid = 0;
      rst = 1'b1;
      #1;
      chk("mid_rst_we", rf_we, 0);
      chk("mid_rst_pend", pend_mask, 0);
      chk("mid_rst_lsu_ready", lsu_ready, 1);
      chk("mid_rst_exe_ready", exe_ready, 1);
      tick();
      rst = 1'b0;
      tick();
      chk("post_rst_we1", rf_we, 0);
      tick();
      chk("post_rst_we2", rf_we, 0);
      chk("post_rst_pend", pend_mask, 0);
      chk("post_rst_wr_cnt", perf_wr_cnt, 0);
      chk("post_rst_stall", perf_stall_cnt, 0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
